// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory_bus between the CPU core and the DMA/loader port.
// A request is accepted only while the arbiter is idle. The winner's address,
// write data and write flag are latched into the bus registers. The bus is
// then held for WAIT_STATES+1 cycles. Read data is captured on the last
// ACCESS edge, and the winner gets a single-cycle ready pulse.
//
// Configuration macro: ARBITER_ROUND_ROBIN_EN
//   defined   - on a tie, the port that did not win the previous grant wins
//   undefined - fixed priority, the CPU wins every tie
//
// Parameters
//   WAIT_STATES       extra bus-hold cycles before read capture (0-7)
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   cpu_*             CPU request/response port
//   dma_*             DMA request/response port
//   bus_address       memory_bus address
//   bus_data_out      memory_bus write data
//   bus_data_in       memory_bus read data
//   bus_enable        memory_bus enable
//   bus_write_enable  memory_bus write strobe
//   owner_dma         status: DMA currently owns the bus
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_data_in,
  input  logic        cpu_write_enable,
  output logic [15:0] cpu_data_out,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic [15:0] dma_address,
  input  logic [15:0] dma_data_in,
  input  logic        dma_write_enable,
  output logic [15:0] dma_data_out,
  output logic        dma_ready,
  output logic [15:0] bus_address,
  output logic [15:0] bus_data_out,
  input  logic [15:0] bus_data_in,
  output logic        bus_enable,
  output logic        bus_write_enable,
  output logic        owner_dma
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [2:0] WAIT_INIT = WAIT_STATES[2:0];

  state_e      state_q,            state_d;
  logic [15:0] bus_address_q,      bus_address_d;
  logic [15:0] bus_data_out_q,     bus_data_out_d;
  logic        bus_enable_q,       bus_enable_d;
  logic        bus_write_enable_q, bus_write_enable_d;
  logic [2:0]  wait_cnt_q,         wait_cnt_d;
  logic        owner_dma_q,        owner_dma_d;
  logic [15:0] cpu_data_out_q,     cpu_data_out_d;
  logic [15:0] dma_data_out_q,     dma_data_out_d;
  logic        cpu_ready_q,        cpu_ready_d;
  logic        dma_ready_q,        dma_ready_d;
`ifdef ARBITER_ROUND_ROBIN_EN
  logic        last_owner_q,       last_owner_d;
`endif

  logic        grant_dma_s;

`ifdef ARBITER_ROUND_ROBIN_EN
  // Winner selection: a tie goes to the port that lost the previous grant.
  always_comb begin
    if (cpu_req && dma_req) begin
      grant_dma_s = ~last_owner_q;
    end else if (dma_req) begin
      grant_dma_s = 1'b1;
    end else begin
      grant_dma_s = 1'b0;
    end
  end
`else
  // Winner selection: the CPU wins every tie.
  always_comb begin
    if (dma_req && !cpu_req) begin
      grant_dma_s = 1'b1;
    end else begin
      grant_dma_s = 1'b0;
    end
  end
`endif

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d            = state_q;
    bus_address_d      = bus_address_q;
    bus_data_out_d     = bus_data_out_q;
    bus_enable_d       = bus_enable_q;
    bus_write_enable_d = bus_write_enable_q;
    wait_cnt_d         = wait_cnt_q;
    owner_dma_d        = owner_dma_q;
    cpu_data_out_d     = cpu_data_out_q;
    dma_data_out_d     = dma_data_out_q;
    cpu_ready_d        = 1'b0;
    dma_ready_d        = 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
    last_owner_d       = last_owner_q;
`endif

    case (state_q)
      ST_IDLE: begin
        bus_enable_d       = 1'b0;
        bus_write_enable_d = 1'b0;
        if (cpu_req || dma_req) begin
          state_d      = ST_ACCESS;
          owner_dma_d  = grant_dma_s;
          bus_enable_d = 1'b1;
          wait_cnt_d   = WAIT_INIT;
`ifdef ARBITER_ROUND_ROBIN_EN
          last_owner_d = grant_dma_s;
`endif
          if (grant_dma_s) begin
            bus_address_d      = dma_address;
            bus_data_out_d     = dma_data_in;
            bus_write_enable_d = dma_write_enable;
          end else begin
            bus_address_d      = cpu_address;
            bus_data_out_d     = cpu_data_in;
            bus_write_enable_d = cpu_write_enable;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (wait_cnt_q != 3'd0) begin
          // Counter saturates at zero; the last ACCESS cycle is the zero one.
          wait_cnt_d = wait_cnt_q - 3'd1;
        end else begin
          state_d            = ST_RELEASE;
          bus_enable_d       = 1'b0;
          bus_write_enable_d = 1'b0;
          if (owner_dma_q) begin
            dma_ready_d = 1'b1;
            if (!bus_write_enable_q) begin
              dma_data_out_d = bus_data_in;
            end else begin
              dma_data_out_d = dma_data_out_q;
            end
          end else begin
            cpu_ready_d = 1'b1;
            if (!bus_write_enable_q) begin
              cpu_data_out_d = bus_data_in;
            end else begin
              cpu_data_out_d = cpu_data_out_q;
            end
          end
        end
      end

      ST_RELEASE: begin
        // Ready is high for this one cycle; ownership ends as we return to idle.
        state_d     = ST_IDLE;
        owner_dma_d = 1'b0;
      end

      default: begin
        state_d            = ST_IDLE;
        bus_enable_d       = 1'b0;
        bus_write_enable_d = 1'b0;
        owner_dma_d        = 1'b0;
        wait_cnt_d         = 3'd0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      bus_address_q      <= 16'h0000;
      bus_data_out_q     <= 16'h0000;
      bus_enable_q       <= 1'b0;
      bus_write_enable_q <= 1'b0;
      wait_cnt_q         <= 3'd0;
      owner_dma_q        <= 1'b0;
      cpu_data_out_q     <= 16'h0000;
      dma_data_out_q     <= 16'h0000;
      cpu_ready_q        <= 1'b0;
      dma_ready_q        <= 1'b0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_owner_q       <= 1'b1;
`endif
    end else begin
      state_q            <= state_d;
      bus_address_q      <= bus_address_d;
      bus_data_out_q     <= bus_data_out_d;
      bus_enable_q       <= bus_enable_d;
      bus_write_enable_q <= bus_write_enable_d;
      wait_cnt_q         <= wait_cnt_d;
      owner_dma_q        <= owner_dma_d;
      cpu_data_out_q     <= cpu_data_out_d;
      dma_data_out_q     <= dma_data_out_d;
      cpu_ready_q        <= cpu_ready_d;
      dma_ready_q        <= dma_ready_d;
`ifdef ARBITER_ROUND_ROBIN_EN
      last_owner_q       <= last_owner_d;
`endif
    end
  end

  assign bus_address      = bus_address_q;
  assign bus_data_out     = bus_data_out_q;
  assign bus_enable       = bus_enable_q;
  assign bus_write_enable = bus_write_enable_q;
  assign owner_dma        = owner_dma_q;
  assign cpu_data_out     = cpu_data_out_q;
  assign dma_data_out     = dma_data_out_q;
  assign cpu_ready        = cpu_ready_q;
  assign dma_ready        = dma_ready_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `memory_bus` between the CPU core and a DMA/loader requester. It serialises requests, holds the bus stable for a configurable number of cycles, captures read data and returns a one-cycle `ready` pulse to the winner. It sits between the requesters and the `memory_bus` instance.

## Interface

- `WAIT_STATES`, 1, extra cycles the bus is held before read data is captured; legal range 0-7.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU requests an access; held with its address/data/write stable until `cpu_ready`.
- `cpu_address`  in  16  CPU address.
- `cpu_data_in`  in  16  CPU write data.
- `cpu_write_enable`  in  1  1 = write, 0 = read.
- `cpu_data_out`  out  16  last read data captured for the CPU.
- `cpu_ready`  out  1  one-cycle completion pulse to the CPU.
- `dma_req`, `dma_address`, `dma_data_in`, `dma_write_enable`, `dma_data_out`, `dma_ready`: same as the `cpu_*` ports, for the DMA port.
- `bus_address`  out  16  to memory_bus `address`.
- `bus_data_out`  out  16  to memory_bus `data_in`.
- `bus_data_in`  in  16  from memory_bus `data_out`.
- `bus_enable`  out  1  to memory_bus `bus_enable`.
- `bus_write_enable`  out  1  to memory_bus `write_enable`.
- `owner_dma`  out  1  1 while the DMA port owns the bus; status only.

## Operation

- The FSM has three states: IDLE, ACCESS and RELEASE.
- **IDLE**
  - The bus outputs are deasserted.
  - If either request is high: pick the winner, latch its address, write data and write_enable into the bus registers, load `wait_cnt = WAIT_STATES`, set `owner_dma`, and go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS**
  - `bus_enable` = 1. `bus_write_enable` = the latched write flag. Address and data are held constant.
  - If `wait_cnt` != 0, decrement it.
  - If `wait_cnt` == 0, go to RELEASE. On that edge:
    - For a read, capture `bus_data_in` into the winner's `*_data_out`.
    - Set the winner's `*_ready` high.
- **RELEASE**
  - `bus_enable` and `bus_write_enable` are 0.
  - `*_ready` is high for exactly this cycle.
  - Always go to IDLE on the next edge.
- Requests are sampled only in IDLE.
  - A requester that sees `ready` may drop `req`, or present a new request, at the RELEASE→IDLE edge. It is never serviced twice for one request.
- Dropping `req` during ACCESS does not abort the transaction. It completes and `ready` still pulses.
- Writes never update `*_data_out`. `*_data_out` holds its value until the next read completes on that port.
- The bus registers are 16-bit with no arithmetic. `wait_cnt` is 3 bits and never wraps: it stops at 0.

## Timing

- Reset values: state IDLE; `bus_address`, `bus_data_out`, `cpu_data_out`, `dma_data_out` = 0; `bus_enable`, `bus_write_enable`, `cpu_ready`, `dma_ready`, `owner_dma` = 0; `wait_cnt` = 0; `last_owner` = 1 (DMA).
- Request seen in IDLE at edge N:
  - Bus is driven during cycles N+1 … N+1+WAIT_STATES.
  - `ready` is high during cycle N+2+WAIT_STATES.
  - FSM is back in IDLE at N+3+WAIT_STATES.
- Peak throughput is one access per WAIT_STATES+3 cycles.
- Read data is sampled at the end of the last ACCESS cycle. `WAIT_STATES` ≥ 1 is required for block-RAM (bank 11) reads, because that bank has registered output.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). No `ready` is issued for the aborted access, and the requester must re-request.

## Configuration

- `ARBITER_ROUND_ROBIN_EN`
  - Defined: when both requests are high in IDLE, the port that did not win last time wins. `last_owner` updates on each grant.
  - Undefined: fixed priority, CPU always wins ties. `last_owner` is unused, and a continuously requesting CPU can starve the DMA port.
- A single request always wins regardless of mode.

## Test plan

- **CPU read, WAIT_STATES=1.** RAM[0x0010]=0xBEEF; `cpu_req` with addr 0x0010 and we=0 at edge 0 → `bus_enable` high cycles 1-2, `cpu_ready` high only in cycle 3, `cpu_data_out`=0xBEEF, `dma_ready` stays 0.
- **DMA write then CPU read.** DMA writes 0x1234 to 0x0020 → `bus_write_enable`=1 for 2 cycles, `dma_ready` pulses, `dma_data_out` unchanged; then a CPU read of 0x0020 returns 0x1234.
- **Simultaneous requests, `ARBITER_ROUND_ROBIN_EN` defined.** Both requests held high for 4 transactions → grant order CPU, DMA, CPU, DMA; each `ready` is one cycle wide; no cycle with both `ready`s high.
- **Same stimulus, macro undefined.** Grants are CPU, CPU, CPU, CPU and `dma_ready` never pulses; after `cpu_req` drops, the DMA is granted in the next IDLE.
- **Reset mid-ACCESS.** Assert `reset` during cycle 1 of a CPU read → `bus_enable`=0 and `cpu_ready`=0 in the same cycle; after release, the state is IDLE and a new request completes normally.
- **Request dropped mid-ACCESS, WAIT_STATES=3.** `cpu_req` falls during cycle 2 → `bus_enable` stays high through cycle 4, `cpu_ready` pulses in cycle 5, and no second transaction starts.
